// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES-128 InvCipher: one round per clock, round keys fetched
// from an external key-schedule store by index.
module inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    function automatic logic [7:0] gmul(logic [7:0] x, logic [7:0] z);
        logic [7:0] p;
        logic [7:0] v;
        p = 8'h00;
        v = x;
        for (int i = 0; i < 8; i++) begin
            if (z[i]) p = p ^ v;
            v = {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] b;
    logic [7:0] sq;
    logic [7:0] acc;

    // Undo the affine map first, then invert in GF(2^8) as b^254.
    assign b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]}
             ^ {a[1:0], a[7:2]} ^ 8'h05;

    always_comb begin
        sq  = b;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gmul(sq, sq);
            acc = gmul(acc, sq);
        end
        y = acc;
    end
endmodule

module aes_inv_cipher_iter #(
    parameter int WIDTH = 128,
    parameter int NR    = 10
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             data_valid_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             ready_o,
    output logic [3:0]       rk_idx_o,
    input  logic [WIDTH-1:0] rk_i,
    output logic [WIDTH-1:0] data_o,
    output logic             done_o
);
    typedef enum logic [1:0] {IDLE, ROUND, FINAL} state_t;

    state_t       fsm;
    logic [3:0]   cnt;
    logic [127:0] st;
    logic [127:0] sr;
    logic [127:0] sb;
    logic [127:0] ark;

    function automatic logic [7:0] xt(logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] cm(logic [7:0] v, logic [3:0] k);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xt(v);
        x4 = xt(x2);
        x8 = xt(x4);
        return (k[0] ? v : 8'h00) ^ (k[1] ? x2 : 8'h00)
             ^ (k[2] ? x4 : 8'h00) ^ (k[3] ? x8 : 8'h00);
    endfunction

    function automatic logic [127:0] isr(logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] =
                    s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] imc(logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a [4];
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++)
                a[i] = s[127-8*(4*c+i) -: 8];
            for (int i = 0; i < 4; i++)
                o[127-8*(4*c+i) -: 8] =
                    cm(a[i], 4'he) ^ cm(a[(i+1)%4], 4'hb)
                  ^ cm(a[(i+2)%4], 4'hd) ^ cm(a[(i+3)%4], 4'h9);
        end
        return o;
    endfunction

    assign sr = isr(st);

    for (genvar k = 0; k < 16; k++) begin : g_sb
        inv_sbox u_sb (
            .a(sr[127-8*k -: 8]),
            .y(sb[127-8*k -: 8])
        );
    end

    assign ark     = sb ^ rk_i;
    assign ready_o = (fsm == IDLE);

    always_comb begin
        rk_idx_o = 4'(NR);
        unique case (fsm)
            ROUND:   rk_idx_o = cnt;
            FINAL:   rk_idx_o = 4'd0;
            default: rk_idx_o = 4'(NR);
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fsm    <= IDLE;
            cnt    <= 4'(NR - 1);
            st     <= '0;
            data_o <= '0;
            done_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            unique case (fsm)
                IDLE: begin
                    if (data_valid_i) begin
                        st  <= data_i ^ rk_i;
                        cnt <= 4'(NR - 1);
                        fsm <= ROUND;
                    end
                end
                ROUND: begin
                    st  <= imc(ark);
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) fsm <= FINAL;
                end
                FINAL: begin
                    data_o <= ark;
                    done_o <= 1'b1;
                    fsm    <= IDLE;
                end
                default: fsm <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_inv_cipher_iter.sv
// Bench for aes_inv_cipher_iter: FIPS-197 vectors, key-index sequence,
// back-to-back, busy-drop and mid-block reset, scoreboard-checked.
module tb_aes_inv_cipher_iter;
    logic         clk_i = 1'b0;
    logic         rst_n_i = 1'b0;
    logic         data_valid_i = 1'b0;
    logic [127:0] data_i = '0;
    logic         ready_o;
    logic [3:0]   rk_idx_o;
    logic [127:0] rk_i;
    logic [127:0] data_o;
    logic         done_o;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_done = 0;
    int prev_done = 0;
    logic         ksel = 1'b0;
    logic [127:0] last_pt = '0;
    logic [127:0] exp_q [$];
    logic [127:0] rk_tab [0:1][0:15];

    localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CTB = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PTB = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KC  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CTC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PTC = 128'h00112233445566778899aabbccddeeff;

    aes_inv_cipher_iter dut (
        .clk_i(clk_i),
        .rst_n_i(rst_n_i),
        .data_valid_i(data_valid_i),
        .data_i(data_i),
        .ready_o(ready_o),
        .rk_idx_o(rk_idx_o),
        .rk_i(rk_i),
        .data_o(data_o),
        .done_o(done_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    always_comb rk_i = rk_tab[ksel][rk_idx_o];

    function automatic logic [7:0] gmul(logic [7:0] x, logic [7:0] z);
        logic [7:0] p;
        logic [7:0] v;
        p = 8'h00;
        v = x;
        for (int i = 0; i < 8; i++) begin
            if (z[i]) p = p ^ v;
            v = {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box: GF inverse by brute search, then affine map.
    function automatic logic [7:0] sbox(logic [7:0] x);
        logic [7:0] b;
        b = 8'h00;
        for (int i = 1; i < 256; i++)
            if (gmul(x, 8'(i)) == 8'h01) b = 8'(i);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
             ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subw(logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]),
                sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    task automatic expand(input logic [127:0] key, input int ks);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++) rk_tab[ks][r] = '0;
        for (int r = 0; r < 11; r++)
            rk_tab[ks][r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic start(input logic ks, input logic [127:0] ct,
                         input logic [127:0] pt);
        chk("ready_before_accept", 128'(ready_o), 128'd1);
        ksel = ks;
        data_i = ct;
        data_valid_i = 1'b1;
        exp_q.push_back(pt);
    endtask

    // Walks the 11 cycles after an accept edge, checking every cycle.
    task automatic track(input int drop_j, input bit keep,
                         input logic [127:0] next_ct);
        int ei;
        for (int j = 0; j <= 10; j++) begin
            @(negedge clk_i);
            ei = (j < 9) ? 9 - j : ((j == 9) ? 0 : 10);
            chk($sformatf("rk_idx_j%0d", j), 128'(rk_idx_o), 128'(ei));
            chk($sformatf("ready_j%0d", j), 128'(ready_o),
                128'(j == 10));
            chk($sformatf("done_j%0d", j), 128'(done_o),
                128'(j == 10));
            if (j < 10) chk("data_hold", data_o, last_pt);
            if (done_o) begin
                chk("sb_size", 128'(exp_q.size()), 128'd1);
                if (exp_q.size() > 0) begin
                    last_pt = exp_q.pop_front();
                    chk("plaintext", data_o, last_pt);
                end
                prev_done = last_done;
                last_done = cyc;
            end
            if (keep) begin
                data_valid_i = 1'b1;
                data_i = next_ct;
            end else if (j == drop_j) begin
                data_valid_i = 1'b1;
                data_i = 128'hdeadbeef_0badf00d_5a5a5a5a_c3c3c3c3;
            end else begin
                data_valid_i = 1'b0;
            end
        end
    endtask

    initial begin
        expand(KB, 0);
        expand(KC, 1);
        chk("rk10_appB", rk_tab[0][10],
            128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_data", data_o, 128'h0);
        chk("rst_done", 128'(done_o), 128'd0);
        chk("rst_ready", 128'(ready_o), 128'd1);
        chk("rst_rk_idx", 128'(rk_idx_o), 128'd10);
        rst_n_i = 1'b1;
        @(negedge clk_i);

        start(1'b0, CTB, PTB);
        track(-1, 1'b0, '0);

        @(negedge clk_i);
        start(1'b1, CTC, PTC);
        track(-1, 1'b0, '0);

        @(negedge clk_i);
        start(1'b0, CTB, PTB);
        track(-1, 1'b1, CTC);
        ksel = 1'b1;
        exp_q.push_back(PTC);
        track(-1, 1'b0, '0);
        chk("b2b_gap", 128'(last_done - prev_done), 128'd11);

        @(negedge clk_i);
        start(1'b0, CTB, PTB);
        track(3, 1'b0, '0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i);
            chk("drop_no_done", 128'(done_o), 128'd0);
            chk("drop_ready", 128'(ready_o), 128'd1);
        end
        chk("drop_sb_empty", 128'(exp_q.size()), 128'd0);

        start(1'b0, CTB, PTB);
        @(negedge clk_i);
        data_valid_i = 1'b0;
        repeat (4) @(negedge clk_i);
        chk("mid_busy", 128'(ready_o), 128'd0);
        rst_n_i = 1'b0;
        #1;
        chk("mrst_data", data_o, 128'h0);
        chk("mrst_done", 128'(done_o), 128'd0);
        chk("mrst_ready", 128'(ready_o), 128'd1);
        chk("mrst_rk_idx", 128'(rk_idx_o), 128'd10);
        exp_q.delete();
        last_pt = '0;
        @(negedge clk_i);
        chk("mrst_no_done", 128'(done_o), 128'd0);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        start(1'b0, CTB, PTB);
        track(-1, 1'b0, '0);
        chk("final_sb_empty", 128'(exp_q.size()), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/aes_inv_cipher_iter.md
Name: aes_inv_cipher_iter

Overview:
- Iterative AES-128 decryptor; mirror of the encrypt round datapath.
- Accepts one 128-bit ciphertext and runs the FIPS-197 InvCipher, one round per clock.
- Round keys come from the external key-schedule store through an index/data lookup. Outputs plaintext with a one-cycle done pulse.
- Sits on the decrypt path alongside the encryptor and shares the key-schedule store with it.

Parameters:
- WIDTH, 128, state/key width. Only 128 is supported.
- NR, 10, number of rounds (AES-128).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- data_valid_i  in  1  ciphertext valid. Sampled only while ready_o=1.
- data_i  in  WIDTH  ciphertext. Byte 0 = bits[127:120]; s[r][c] = byte 4c+r.
- ready_o  out  1  core idle and able to accept a block.
- rk_idx_o  out  4  round-key index requested, range 0..10.
- rk_i  in  WIDTH  round key for rk_idx_o, valid combinationally in the same cycle.
- data_o  out  WIDTH  plaintext result, registered.
- done_o  out  1  one-cycle pulse when data_o updates.

Behaviour:
- Reset values: data_o=0, done_o=0, ready_o=1, rk_idx_o=10, FSM=IDLE, round counter=9.
- Reset is asynchronous, so any mid-operation assertion aborts the block immediately. No partial result is ever presented.
- FSM states: IDLE, ROUND, FINAL.
- IDLE:
  - ready_o=1, rk_idx_o=10.
  - On data_valid_i=1 at a clock edge: state <= data_i ^ rk_i, cnt <= 9, go to ROUND.
  - data_valid_i is ignored in every other state.
- ROUND:
  - rk_idx_o=cnt.
  - Each edge: state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_i).
  - cnt decrements. When cnt=1 at the edge, go to FINAL.
- FINAL:
  - rk_idx_o=0.
  - On the edge: data_o <= InvSubBytes(InvShiftRows(state)) ^ rk_i, done_o <= 1, go to IDLE.
- done_o is high for exactly the one cycle following the FINAL edge, else 0.
- Latency: accept edge T; rounds 9..1 at edges T+1..T+9; result at edge T+10. done_o is high during cycle T+10..T+11.
- Back-to-back: ready_o returns to 1 in the same cycle done_o is high. A new block may be accepted at that edge, giving throughput of 1 block per 11 cycles.
- data_o holds its value until the next FINAL edge. It is not cleared when a new block is accepted.
- InvShiftRows: row r rotates right by r bytes. Row 0 is unchanged.
- InvSubBytes: 16 instances of a separate combinational inv_sbox (8-bit in, 8-bit out) module.
- InvMixColumns:
  - Per column: [0e 0b 0d 09] circulant over GF(2^8), polynomial 0x11B.
  - Built from an xtime chain. No multipliers or tables.
- rk_idx_o is a pure function of FSM state and cnt (decoded from registers) and is glitch-stable within the cycle.
- Behaviour on data_valid_i while busy: dropped silently. The upstream block must honour ready_o.

Test Plan:
- FIPS-197 App.B:
  - Key 2b7e151628aed2a6abf7158809cf4f3c; model supplies rk[0..10], rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Ciphertext 3925841d02dc09fbdc118597196a0b32 -> data_o=3243f6a8885a308d313198a2e0370734.
  - done_o pulses exactly 10 edges after accept.
- FIPS-197 App.C.1: key 000102…0f, ciphertext 69c4e0d86a7b0430d8cdb78070b4c55a -> data_o=00112233445566778899aabbccddeeff.
- rk_idx_o sequence check: after accept, rk_idx_o reads 9,8,…,1,0 on consecutive cycles, then 10 in IDLE. ready_o=0 for exactly 10 cycles.
- Back-to-back:
  - App.B block accepted, then data_valid_i held high with the App.C.1 block.
  - Second block is accepted on the done_o cycle edge.
  - Both results are correct; done_o pulses 11 cycles apart.
- Busy-drop: pulse data_valid_i with garbage at cycle T+4 -> result still 3243f6a8…0734 and no extra done_o.
- Reset mid-operation:
  - Assert rst_n_i at cycle T+5 -> data_o=0, done_o=0, ready_o=1, rk_idx_o=10 immediately.
  - After release, a fresh App.B block decrypts correctly.
